// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush and optional first-word-fall-through read.
module synch_fifo_param #(
    parameter int unsigned fifo_w    = 32,
    parameter int unsigned fifo_d    = 16,
    parameter int unsigned af_thresh = 14,
    parameter int unsigned ae_thresh = 2,
    parameter int unsigned fwft      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_en,
    input  logic                      pop_en,
    input  logic                      flush,
    input  logic                      clr_err,
    input  logic [fifo_w-1:0]         fifo_din,
    output logic [fifo_w-1:0]         fifo_dout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(fifo_d):0]   fifo_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned AW = $clog2(fifo_d);
    localparam int unsigned CW = AW + 1;

    logic [fifo_w-1:0] mem [fifo_d];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              unf_set;

    // A push into a full FIFO is allowed only when a pop frees a slot on the same edge;
    // flush masks both requests and suppresses any error they would raise.
    always_comb begin
        pop_ok    = pop_en && !empty && !flush;
        push_ok   = push_en && (!full || pop_ok) && !flush;
        ovf_set   = push_en && !push_ok && !flush;
        unf_set   = pop_en && !pop_ok && !flush;
        count_nxt = count_q;
        if (flush)
            count_nxt = '0;
        else if (push_ok && !pop_ok)
            count_nxt = count_q + CW'(1);
        else if (!push_ok && pop_ok)
            count_nxt = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            count_q      <= count_nxt;
            full         <= (count_nxt == CW'(fifo_d));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(af_thresh));
            almost_empty <= (count_nxt <= CW'(ae_thresh));
            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (unf_set)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= fifo_din;
    end

    assign fifo_count = count_q;

    generate
        if (fwft != 0) begin : g_fwft
            assign fifo_dout = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [fifo_w-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    dout_q <= '0;
                else if (pop_ok)
                    dout_q <= mem[rd_ptr];
            end
            assign fifo_dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_synch_fifo_param.sv
// Directed bench for synch_fifo_param: one standard-read instance and one FWFT instance.
module tb_synch_fifo_param;

    logic        clk;
    logic        rst;

    logic        s_push, s_pop, s_flush, s_clr;
    logic [31:0] s_din, s_dout;
    logic        s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0]  s_cnt;

    logic        f_push, f_pop, f_flush, f_clr;
    logic [31:0] f_din, f_dout;
    logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0]  f_cnt;

    int unsigned checks;
    int unsigned errors;

    synch_fifo_param #(
        .fifo_w(32), .fifo_d(16), .af_thresh(14), .ae_thresh(2), .fwft(0)
    ) u_std (
        .clk(clk), .rst(rst), .push_en(s_push), .pop_en(s_pop), .flush(s_flush),
        .clr_err(s_clr), .fifo_din(s_din), .fifo_dout(s_dout), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .fifo_count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
    );

    synch_fifo_param #(
        .fifo_w(32), .fifo_d(16), .af_thresh(14), .ae_thresh(2), .fwft(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .push_en(f_push), .pop_en(f_pop), .flush(f_flush),
        .clr_err(f_clr), .fifo_din(f_din), .fifo_dout(f_dout), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .fifo_count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        {s_push, s_pop, s_flush, s_clr} = '0;
        {f_push, f_pop, f_flush, f_clr} = '0;
        s_din = '0;
        f_din = '0;
        #12;

        check("rst_cnt",   64'(s_cnt),   64'd0);
        check("rst_empty", 64'(s_empty), 64'd1);
        check("rst_ae",    64'(s_ae),    64'd1);
        check("rst_full",  64'(s_full),  64'd0);
        check("rst_af",    64'(s_af),    64'd0);
        check("rst_ovf",   64'(s_ovf),   64'd0);
        check("rst_unf",   64'(s_unf),   64'd0);
        check("rst_dout",  64'(s_dout),  64'd0);
        check("rst_fdout", 64'(f_dout),  64'd0);
        rst = 1'b0;

        // Ordering
        s_push = 1'b1;
        s_din = 32'hA1A1A1A1; step();
        s_din = 32'hB2B2B2B2; step();
        s_din = 32'hC3C3C3C3; step();
        s_push = 1'b0;
        check("t1_cnt3", 64'(s_cnt), 64'd3);
        s_pop = 1'b1;
        step(); check("t1_d0", 64'(s_dout), 64'hA1A1A1A1); check("t1_c2", 64'(s_cnt), 64'd2);
        step(); check("t1_d1", 64'(s_dout), 64'hB2B2B2B2); check("t1_c1", 64'(s_cnt), 64'd1);
        step(); check("t1_d2", 64'(s_dout), 64'hC3C3C3C3); check("t1_c0", 64'(s_cnt), 64'd0);
        s_pop = 1'b0;
        check("t1_empty", 64'(s_empty), 64'd1);
        check("t1_ovf",   64'(s_ovf),   64'd0);
        check("t1_unf",   64'(s_unf),   64'd0);

        // Fill, overflow, drain with pointer wrap
        s_push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_din = 32'(i);
            step();
            if (i == 12) check("t2_af13", 64'(s_af), 64'd0);
            if (i == 13) check("t2_af14", 64'(s_af), 64'd1);
            if (i == 14) check("t2_full15", 64'(s_full), 64'd0);
        end
        check("t2_full16", 64'(s_full), 64'd1);
        check("t2_cnt16",  64'(s_cnt),  64'd16);
        s_din = 32'hFF; step();
        s_push = 1'b0;
        check("t2_ovf_cnt", 64'(s_cnt), 64'd16);
        check("t2_ovf",     64'(s_ovf), 64'd1);
        s_pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("t2_drain", 64'(s_dout), 64'(i));
            if (i == 0) check("t2_full_drop", 64'(s_full), 64'd0);
        end
        s_pop = 1'b0;
        check("t2_empty", 64'(s_empty), 64'd1);
        check("t2_unf",   64'(s_unf),   64'd0);
        s_clr = 1'b1; step(); s_clr = 1'b0;
        check("t2_clr", 64'(s_ovf), 64'd0);

        // Simultaneous push/pop at full, then at empty
        s_push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_din = 32'h10 + 32'(i);
            step();
        end
        s_din = 32'hAA; s_pop = 1'b1; step();
        s_push = 1'b0;
        check("t3_cnt",  64'(s_cnt),  64'd16);
        check("t3_full", 64'(s_full), 64'd1);
        check("t3_ovf",  64'(s_ovf),  64'd0);
        check("t3_head", 64'(s_dout), 64'h10);
        for (int i = 0; i < 16; i++) begin
            step();
            check("t3_drain", 64'(s_dout), (i < 15) ? 64'h11 + 64'(i) : 64'hAA);
        end
        s_pop = 1'b0;
        check("t3_empty", 64'(s_empty), 64'd1);
        s_push = 1'b1; s_pop = 1'b1; s_din = 32'h55; step();
        s_push = 1'b0; s_pop = 1'b0;
        check("t3_e_cnt",  64'(s_cnt),  64'd1);
        check("t3_e_unf",  64'(s_unf),  64'd1);
        check("t3_e_dout", 64'(s_dout), 64'hAA);
        s_clr = 1'b1; step(); s_clr = 1'b0;
        check("t3_clr", 64'(s_unf), 64'd0);
        s_pop = 1'b1; step(); s_pop = 1'b0;
        check("t3_pop55", 64'(s_dout), 64'h55);

        // Underflow and almost_empty
        s_pop = 1'b1; step(); s_pop = 1'b0;
        check("t4_unf",  64'(s_unf),  64'd1);
        check("t4_dout", 64'(s_dout), 64'h55);
        check("t4_cnt",  64'(s_cnt),  64'd0);
        s_clr = 1'b1; step(); s_clr = 1'b0;
        s_push = 1'b1;
        s_din = 32'd1; step();
        s_din = 32'd2; step();
        check("t4_ae2", 64'(s_ae), 64'd1);
        s_din = 32'd3; step();
        check("t4_ae3", 64'(s_ae), 64'd0);

        // Flush with push, then asynchronous reset mid-cycle
        s_din = 32'd4; step();
        s_din = 32'd5; step();
        check("t6_cnt5", 64'(s_cnt), 64'd5);
        s_flush = 1'b1; s_din = 32'h99; step();
        s_flush = 1'b0; s_push = 1'b0;
        check("t6_f_cnt",   64'(s_cnt),   64'd0);
        check("t6_f_empty", 64'(s_empty), 64'd1);
        check("t6_f_ovf",   64'(s_ovf),   64'd0);
        check("t6_f_dout",  64'(s_dout),  64'h55);
        s_push = 1'b1;
        s_din = 32'd7; step();
        s_din = 32'd8; step();
        s_din = 32'd9; step();
        s_push = 1'b0;
        check("t6_cnt3", 64'(s_cnt), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("t6_r_cnt",   64'(s_cnt),   64'd0);
        check("t6_r_empty", 64'(s_empty), 64'd1);
        check("t6_r_dout",  64'(s_dout),  64'd0);
        rst = 1'b0;
        s_push = 1'b1; s_din = 32'h42; step();
        s_push = 1'b0; s_pop = 1'b1; step();
        s_pop = 1'b0;
        check("t6_post_d", 64'(s_dout), 64'h42);
        check("t6_post_c", 64'(s_cnt),  64'd0);

        // FWFT instance
        f_push = 1'b1; f_din = 32'hD4D4D4D4; step();
        f_push = 1'b0;
        check("t5_head", 64'(f_dout), 64'hD4D4D4D4);
        check("t5_cnt1", 64'(f_cnt),  64'd1);
        f_push = 1'b1; f_din = 32'hE5E5E5E5; step();
        f_push = 1'b0;
        check("t5_hold", 64'(f_dout), 64'hD4D4D4D4);
        f_pop = 1'b1; step();
        check("t5_next", 64'(f_dout), 64'hE5E5E5E5);
        step();
        f_pop = 1'b0;
        check("t5_empty", 64'(f_empty), 64'd1);
        check("t5_zero",  64'(f_dout),  64'd0);
        check("t5_unf0",  64'(f_unf),   64'd0);
        f_push = 1'b1; f_pop = 1'b1; f_din = 32'h77; step();
        f_push = 1'b0; f_pop = 1'b0;
        check("t5_pp_dout", 64'(f_dout), 64'h77);
        check("t5_pp_unf",  64'(f_unf),  64'd1);
        check("t5_pp_cnt",  64'(f_cnt),  64'd1);
        f_flush = 1'b1; step(); f_flush = 1'b0;
        check("t5_fl_dout",  64'(f_dout),  64'd0);
        check("t5_fl_empty", 64'(f_empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
